// File: rtl/contador_ctrl_pkg.sv
// Shared encodings and helpers for the up/down counter controller.
package contador_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_DOWN = 1'b0,
        GRANT_UP   = 1'b1
    } grant_t;

    // Timer must hold the larger of the two reload values.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/contador_ctrl_timer.sv
// Loadable down-counter; expire flags the last cycle of an interval.
module contador_ctrl_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);

    logic [W-1:0] value;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (en && (value != '0)) begin
            value <= value - W'(1);
        end
    end

    assign expire = (value == W'(1));

endmodule

// File: rtl/contador_ctrl.sv
// Arbitrates up/down requests into single-cycle counter commands with auto-repeat.
// Define CONTADOR_CTRL_WRAP_EN to let pulses pass at the count limits.
module contador_ctrl
    import contador_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH         = DEF_WIDTH,
    parameter int unsigned MAX_VAL       = 15,
    parameter int unsigned MIN_VAL       = 0,
    parameter int unsigned HOLD_CYCLES   = 8,
    parameter int unsigned REPEAT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_up,
    input  logic             req_down,
    input  logic [WIDTH-1:0] count,
    output logic             up,
    output logic             down,
    output logic             busy,
    output logic             at_max,
    output logic             at_min
);

    localparam int unsigned TW = timer_width(HOLD_CYCLES, REPEAT_CYCLES);

    state_t         state, state_next;
    grant_t         grant, grant_next;
    grant_t         last_grant, last_next;
    grant_t         pick;
    logic           up_next, down_next, busy_next;
    logic           issue, held;
    logic           tmr_load, tmr_en, expire;
    logic [TW-1:0]  tmr_val;
    logic           allow_up, allow_down;

    assign at_max = (count == WIDTH'(MAX_VAL));
    assign at_min = (count == WIDTH'(MIN_VAL));

`ifdef CONTADOR_CTRL_WRAP_EN
    assign allow_up   = 1'b1;
    assign allow_down = 1'b1;
`else
    assign allow_up   = !at_max;
    assign allow_down = !at_min;
`endif

    contador_ctrl_timer #(
        .W(TW)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .load_val(tmr_val),
        .en      (tmr_en),
        .expire  (expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= GRANT_DOWN;
            last_grant <= GRANT_DOWN;
            up         <= 1'b0;
            down       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_next;
            up         <= up_next;
            down       <= down_next;
            busy       <= busy_next;
        end
    end

    // Ties alternate starting from up; the timer advances even when a pulse is suppressed.
    always_comb begin
        state_next = state;
        grant_next = grant;
        last_next  = last_grant;
        issue      = 1'b0;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
        tmr_val    = TW'(HOLD_CYCLES);
        held       = (grant == GRANT_UP) ? req_up : req_down;

        if (req_up && req_down) begin
            pick = (last_grant == GRANT_UP) ? GRANT_DOWN : GRANT_UP;
        end else begin
            pick = req_up ? GRANT_UP : GRANT_DOWN;
        end

        case (state)
            IDLE: begin
                if (req_up || req_down) begin
                    grant_next = pick;
                    if (req_up && req_down) begin
                        last_next = pick;
                    end
                    state_next = HOLD;
                    tmr_load   = 1'b1;
                    tmr_val    = TW'(HOLD_CYCLES);
                    issue      = 1'b1;
                end
            end
            HOLD, REPEAT: begin
                if (!held) begin
                    state_next = IDLE;
                end else begin
                    tmr_en = 1'b1;
                    if (expire) begin
                        issue      = 1'b1;
                        tmr_load   = 1'b1;
                        tmr_val    = TW'(REPEAT_CYCLES);
                        state_next = REPEAT;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        up_next   = issue && (grant_next == GRANT_UP) && allow_up;
        down_next = issue && (grant_next == GRANT_DOWN) && allow_down;
        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_contador_ctrl.sv
// Self-checking bench for contador_ctrl: directed table, corner sequences, random vs model.
module tb_contador_ctrl;

    localparam int unsigned H    = 8;
    localparam int unsigned R    = 4;
    localparam int unsigned MAXV = 15;
    localparam int unsigned MINV = 0;
`ifdef CONTADOR_CTRL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       req_up   = 1'b0;
    logic       req_down = 1'b0;
    logic [3:0] count    = 4'd0;
    logic       up, down, busy, at_max, at_min;

    int n_tests = 0;
    int n_fail  = 0;

    contador_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .req_up  (req_up),
        .req_down(req_down),
        .count   (count),
        .up      (up),
        .down    (down),
        .busy    (busy),
        .at_max  (at_max),
        .at_min  (at_min)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ru;
        logic       rd;
        logic [3:0] cnt;
        logic       e_up;
        logic       e_down;
        logic       e_busy;
        logic       e_max;
        logic       e_min;
    } vec_t;

    vec_t vecs[17];

    // Reference model state: press age in edges since the grant.
    bit          m_active;
    bit          m_dir_up;
    bit          m_last_up;
    int unsigned m_age;
    logic        m_up, m_down, m_busy;

    task automatic chk(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_edge(input logic rst, input logic ru, input logic rd, input logic [3:0] c);
        reset    = rst;
        req_up   = ru;
        req_down = rd;
        count    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic rst, input logic ru, input logic rd, input logic [3:0] c);
        bit due;
        due    = 1'b0;
        m_up   = 1'b0;
        m_down = 1'b0;
        if (!rst) begin
            m_active  = 1'b0;
            m_last_up = 1'b0;
        end else if (!m_active) begin
            if (ru || rd) begin
                if (ru && rd) begin
                    m_dir_up  = !m_last_up;
                    m_last_up = m_dir_up;
                end else begin
                    m_dir_up = ru;
                end
                m_active = 1'b1;
                m_age    = 0;
                due      = 1'b1;
            end
        end else if (m_dir_up ? ru : rd) begin
            m_age++;
            due = (m_age == H) || ((m_age > H) && (((m_age - H) % R) == 0));
        end else begin
            m_active = 1'b0;
        end
        if (due) begin
            if (m_dir_up) m_up = WRAP || (c != 4'(MAXV));
            else          m_down = WRAP || (c != 4'(MINV));
        end
        m_busy = m_active;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    task automatic hold_seq(input logic [3:0] c, input logic on, input string tag);
        logic exp;
        pulse_reset();
        for (int i = 0; i < 20; i++) begin
            drive_edge(1'b1, 1'b1, 1'b0, c);
            exp = on && (i == 0 || i == 8 || i == 12 || i == 16);
            chk({tag, "_up"}, up, exp);
            chk({tag, "_down"}, down, 1'b0);
        end
        chk({tag, "_at_max"}, at_max, c == 4'(MAXV));
        for (int i = 0; i < 4; i++) begin
            drive_edge(1'b1, 1'b0, 1'b0, c);
            chk({tag, "_rel_up"}, up, 1'b0);
            chk({tag, "_rel_busy"}, busy, 1'b0);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'd5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 4'd5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 4'd5,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 4'd5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 4'd0,  1'b0, WRAP, 1'b1, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset asserted with a request present: everything idle.
        req_up = 1'b1;
        count  = 4'd0;
        #2 reset = 1'b0;
        #1;
        chk("rst_up", up, 1'b0);
        chk("rst_down", down, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_at_min", at_min, 1'b1);
        chk("rst_at_max", at_max, 1'b0);

        for (int i = 0; i < 17; i++) begin
            drive_edge(vecs[i].rst, vecs[i].ru, vecs[i].rd, vecs[i].cnt);
            chk($sformatf("vec%0d_up", i), up, vecs[i].e_up);
            chk($sformatf("vec%0d_down", i), down, vecs[i].e_down);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("vec%0d_at_max", i), at_max, vecs[i].e_max);
            chk($sformatf("vec%0d_at_min", i), at_min, vecs[i].e_min);
        end

        hold_seq(4'd5, 1'b1, "hold");
        hold_seq(4'd15, WRAP, "sat");

        // Reset while repeating, then a held down request starts fresh.
        pulse_reset();
        for (int i = 0; i <= 12; i++) begin
            drive_edge(1'b1, 1'b1, 1'b0, 4'd5);
        end
        chk("midrst_pre_up", up, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk("midrst_up", up, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            drive_edge(1'b1, 1'b0, 1'b1, 4'd5);
            chk($sformatf("midrst_down%0d", i), down, (i == 0) || (i == 8));
            chk($sformatf("midrst_busy%0d", i), busy, 1'b1);
            chk($sformatf("midrst_noup%0d", i), up, 1'b0);
        end

        // Random traffic against the reference model.
        begin
            logic       r_rst, r_ru, r_rd;
            logic [3:0] r_c;
            r_ru = 1'b0;
            r_rd = 1'b0;
            r_c  = 4'd7;
            drive_edge(1'b0, 1'b0, 1'b0, r_c);
            model_step(1'b0, 1'b0, 1'b0, r_c);
            for (int n = 0; n < 3000; n++) begin
                r_rst = ($urandom_range(0, 99) != 0);
                if ($urandom_range(0, 5) == 0) r_ru = ~r_ru;
                if ($urandom_range(0, 5) == 0) r_rd = ~r_rd;
                if ($urandom_range(0, 7) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       r_c = 4'(MINV);
                        1:       r_c = 4'(MAXV);
                        default: r_c = 4'($urandom_range(0, 15));
                    endcase
                end
                drive_edge(r_rst, r_ru, r_rd, r_c);
                model_step(r_rst, r_ru, r_rd, r_c);
                chk($sformatf("rnd%0d_up", n), up, m_up);
                chk($sformatf("rnd%0d_down", n), down, m_down);
                chk($sformatf("rnd%0d_busy", n), busy, m_busy);
                chk($sformatf("rnd%0d_at_max", n), at_max, r_c == 4'(MAXV));
                chk($sformatf("rnd%0d_at_min", n), at_min, r_c == 4'(MINV));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
